// File: rtl/wb_mcb_arb_2_pkg.sv
// ============================================================================
// Module  : wb_mcb_arb_2_pkg
// Brief   : Shared arbiter state encodings and watchdog defaults for MCB-side blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_mcb_arb_2_pkg;

    localparam int WB_TIMEOUT_DEFAULT = 1024;
    localparam int WB_CNT_W_DEFAULT   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_mcb_arb_2_if.sv
// ============================================================================
// Module  : wb_mcb_arb_2_if
// Brief   : Single Wishbone link; master modport drives the request side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_mcb_arb_2_if;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        err;

    modport master (
        output adr, wdat, we, sel, stb, cyc,
        input  rdat, ack, err
    );

    modport slave (
        input  adr, wdat, we, sel, stb, cyc,
        output rdat, ack, err
    );
endinterface

`default_nettype wire

// File: rtl/wb_mcb_arb_2_watchdog.sv
// ============================================================================
// Module  : wb_watchdog
// Brief   : Counts unacknowledged strobe cycles; one-cycle registered pulse at limit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_watchdog #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             stb,
    input  wire logic             ack,
    input  wire logic [CNT_W-1:0] limit,
    output logic                  timeout
);

    logic [CNT_W-1:0] cnt;
    logic             enabled;
    logic [CNT_W-1:0] last_cnt;

    assign enabled  = (limit != '0);
    assign last_cnt = limit - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            // An ack arriving on the limit cycle wins over the timeout.
            if (!stb || ack) begin
                cnt <= '0;
            end else if (enabled && (cnt == last_cnt)) begin
                cnt     <= '0;
                timeout <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_mcb_arb_2.sv
// ============================================================================
// Module  : wb_mcb_arb_2
// Brief   : Two-master round-robin Wishbone arbiter in front of the MCB wrapper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mcb_arb_2
    import wb_mcb_arb_2_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT_DEFAULT,
    parameter int CNT_W   = WB_CNT_W_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      rst,
    wb_mcb_arb_2_if.slave  wbm0,
    wb_mcb_arb_2_if.slave  wbm1,
    wb_mcb_arb_2_if.master wbs
);

    arb_state_t state, state_nxt;
    logic       last_reg, last_nxt;
    logic       req0, req1;
    logic       timeout;

    assign req0 = wbm0.cyc & wbm0.stb;
    assign req1 = wbm1.cyc & wbm1.stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_reg <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_reg <= last_nxt;
        end
    end

    // last_reg records the most recently served master; the other one wins ties.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_reg;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_reg)) begin
                    state_nxt = GRANT0;
                end else if (req1) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (!wbm0.cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            GRANT1: begin
                if (!wbm1.cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wbs.adr  = '0;
        wbs.wdat = '0;
        wbs.we   = 1'b0;
        wbs.sel  = '0;
        wbs.stb  = 1'b0;
        wbs.cyc  = 1'b0;
        case (state)
            GRANT0: begin
                wbs.adr  = wbm0.adr;
                wbs.wdat = wbm0.wdat;
                wbs.we   = wbm0.we;
                wbs.sel  = wbm0.sel;
                wbs.stb  = wbm0.stb;
                wbs.cyc  = wbm0.cyc;
            end
            GRANT1: begin
                wbs.adr  = wbm1.adr;
                wbs.wdat = wbm1.wdat;
                wbs.we   = wbm1.we;
                wbs.sel  = wbm1.sel;
                wbs.stb  = wbm1.stb;
                wbs.cyc  = wbm1.cyc;
            end
            default: ;
        endcase
    end

    assign wbm0.ack  = wbs.ack & (state == GRANT0);
    assign wbm1.ack  = wbs.ack & (state == GRANT1);
    assign wbm0.rdat = wbs.rdat;
    assign wbm1.rdat = wbs.rdat;

    // Qualifying with cyc makes an aborted transfer clear the counter immediately.
    wb_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stb     (wbs.stb & wbs.cyc),
        .ack     (wbs.ack),
        .limit   (CNT_W'(TIMEOUT)),
        .timeout (timeout)
    );

    assign wbm0.err = timeout & (state == GRANT0);
    assign wbm1.err = timeout & (state == GRANT1);

endmodule

`default_nettype wire

// File: tb/tb_wb_mcb_arb_2.sv
// ============================================================================
// Module  : tb_wb_mcb_arb_2
// Brief   : Directed self-checking bench for the two-master arbiter (TIMEOUT=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_mcb_arb_2;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    wb_mcb_arb_2_if m0 ();
    wb_mcb_arb_2_if m1 ();
    wb_mcb_arb_2_if s  ();

    wb_mcb_arb_2 #(
        .TIMEOUT (8),
        .CNT_W   (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wbm0 (m0.slave),
        .wbm1 (m1.slave),
        .wbs  (s.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_set(input logic on, input logic [31:0] adr,
                          input logic [31:0] dat, input logic we);
        m0.cyc = on; m0.stb = on; m0.adr = adr; m0.wdat = dat; m0.we = we; m0.sel = 4'hF;
    endtask

    task automatic m1_set(input logic on, input logic [31:0] adr,
                          input logic [31:0] dat, input logic we);
        m1.cyc = on; m1.stb = on; m1.adr = adr; m1.wdat = dat; m1.we = we; m1.sel = 4'h3;
    endtask

    task automatic do_reset();
        m0_set(1'b0, 32'h0, 32'h0, 1'b0);
        m1_set(1'b0, 32'h0, 32'h0, 1'b0);
        s.ack = 1'b0; s.rdat = 32'h0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        m0_set(1'b1, 32'h4, 32'h1, 1'b1);
        s.ack = 1'b1; s.rdat = 32'h0; s.err = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (s.cyc !== 1'b0) $display("FAIL reset_cyc got %b exp 0", s.cyc); else passed++;
        checks++; if (s.stb !== 1'b0) $display("FAIL reset_stb got %b exp 0", s.stb); else passed++;
        checks++; if (m0.ack !== 1'b0) $display("FAIL reset_ack0 got %b exp 0", m0.ack); else passed++;
        checks++; if (m0.err !== 1'b0) $display("FAIL reset_err0 got %b exp 0", m0.err); else passed++;
        checks++; if (s.adr !== 32'h0) $display("FAIL reset_adr got %h exp 0", s.adr); else passed++;
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        m0_set(1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        #1;
        checks++; if (s.cyc !== 1'b0) $display("FAIL single_latency got %b exp 0", s.cyc); else passed++;
        tick();
        checks++; if (s.cyc !== 1'b1) $display("FAIL single_cyc got %b exp 1", s.cyc); else passed++;
        checks++; if (s.adr !== 32'h100) $display("FAIL single_adr got %h exp 100", s.adr); else passed++;
        checks++; if (s.wdat !== 32'hDEADBEEF) $display("FAIL single_dat got %h exp deadbeef", s.wdat); else passed++;
        checks++; if (s.sel !== 4'hF || s.we !== 1'b1) $display("FAIL single_sel_we got %h/%b exp f/1", s.sel, s.we); else passed++;
        s.ack = 1'b1; s.rdat = 32'h12345678;
        #1;
        checks++; if (m0.ack !== 1'b1) $display("FAIL single_ack0 got %b exp 1", m0.ack); else passed++;
        checks++; if (m1.ack !== 1'b0) $display("FAIL single_ack1 got %b exp 0", m1.ack); else passed++;
        checks++; if (m1.rdat !== 32'h12345678) $display("FAIL single_rdat1 got %h exp 12345678", m1.rdat); else passed++;
        tick();
        s.ack = 1'b0;
        m0_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (s.cyc !== 1'b0) $display("FAIL single_release got %b exp 0", s.cyc); else passed++;
    endtask

    task automatic test_tie();
        do_reset();
        m0_set(1'b1, 32'hA0, 32'h0, 1'b0);
        m1_set(1'b1, 32'hB0, 32'h0, 1'b0);
        tick();
        checks++; if (s.adr !== 32'hA0) $display("FAIL tie1_winner got %h exp a0", s.adr); else passed++;
        s.ack = 1'b1;
        #1;
        checks++; if (m1.ack !== 1'b0) $display("FAIL tie1_ack1 got %b exp 0", m1.ack); else passed++;
        tick();
        s.ack = 1'b0;
        m0_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (s.cyc !== 1'b0) $display("FAIL tie1_idle got %b exp 0", s.cyc); else passed++;
        tick();
        checks++; if (s.cyc !== 1'b1 || s.adr !== 32'hB0) $display("FAIL tie1_m1_grant got %b/%h exp 1/b0", s.cyc, s.adr); else passed++;
        // m1 served last, so the next tie goes to m0; after that to m1.
        m1_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick(); tick();
        m0_set(1'b1, 32'hA4, 32'h0, 1'b0);
        m1_set(1'b1, 32'hB4, 32'h0, 1'b0);
        tick();
        checks++; if (s.adr !== 32'hA4) $display("FAIL tie2_winner got %h exp a4", s.adr); else passed++;
        m0_set(1'b0, 32'h0, 32'h0, 1'b0);
        m1_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick(); tick();
        m0_set(1'b1, 32'hA8, 32'h0, 1'b0);
        m1_set(1'b1, 32'hB8, 32'h0, 1'b0);
        tick();
        checks++; if (s.adr !== 32'hB8) $display("FAIL tie3_winner got %h exp b8", s.adr); else passed++;
        m0_set(1'b0, 32'h0, 32'h0, 1'b0);
        m1_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick(); tick();
    endtask

    task automatic test_burst();
        logic [31:0] exp_adr;
        do_reset();
        m1_set(1'b1, 32'h200, 32'h0, 1'b0);
        tick();
        m0_set(1'b1, 32'h300, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_adr = 32'h200 + 32'(4 * i);
            m1.adr = exp_adr;
            s.ack = 1'b1; s.rdat = 32'hC0 + 32'(i);
            #1;
            checks++; if (s.adr !== exp_adr) $display("FAIL burst_adr%0d got %h exp %h", i, s.adr, exp_adr); else passed++;
            checks++; if (m1.ack !== 1'b1 || m0.ack !== 1'b0) $display("FAIL burst_ack%0d got m1=%b m0=%b exp 1/0", i, m1.ack, m0.ack); else passed++;
            checks++; if (m1.rdat !== 32'hC0 + 32'(i)) $display("FAIL burst_rdat%0d got %h exp %h", i, m1.rdat, 32'hC0 + 32'(i)); else passed++;
            tick();
        end
        s.ack = 1'b0;
        m1_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (s.cyc !== 1'b0) $display("FAIL burst_idle got %b exp 0", s.cyc); else passed++;
        tick();
        checks++; if (s.cyc !== 1'b1 || s.adr !== 32'h300) $display("FAIL burst_m0_grant got %b/%h exp 1/300", s.cyc, s.adr); else passed++;
        m0_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick(); tick();
    endtask

    task automatic test_timeout();
        logic exp_err;
        do_reset();
        m0_set(1'b1, 32'h400, 32'h0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_err = (k == 9);
            checks++; if (m0.err !== exp_err) $display("FAIL timeout_err_k%0d got %b exp %b", k, m0.err, exp_err); else passed++;
            if (m1.err !== 1'b0) begin
                checks++; $display("FAIL timeout_err1_k%0d got %b exp 0", k, m1.err);
            end
        end
        checks++; if (s.cyc !== 1'b1) $display("FAIL timeout_grant_held got %b exp 1", s.cyc); else passed++;
        m0_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick(); tick();
        m0_set(1'b1, 32'h404, 32'h0, 1'b0);
        for (int k = 1; k <= 8; k++) tick();
        s.ack = 1'b1;
        #1;
        checks++; if (m0.ack !== 1'b1) $display("FAIL limit_ack got %b exp 1", m0.ack); else passed++;
        tick();
        checks++; if (m0.err !== 1'b0) $display("FAIL limit_ack_err got %b exp 0", m0.err); else passed++;
        s.ack = 1'b0;
        tick();
        checks++; if (m0.err !== 1'b0) $display("FAIL limit_ack_err2 got %b exp 0", m0.err); else passed++;
        m0_set(1'b0, 32'h0, 32'h0, 1'b0);
        tick(); tick();
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        m1_set(1'b1, 32'h500, 32'h0, 1'b0);
        tick();
        checks++; if (s.cyc !== 1'b1) $display("FAIL rstmid_grant got %b exp 1", s.cyc); else passed++;
        rst = 1'b1;
        tick();
        checks++; if (s.cyc !== 1'b0) $display("FAIL rstmid_cyc got %b exp 0", s.cyc); else passed++;
        rst = 1'b0;
        m1_set(1'b0, 32'h0, 32'h0, 1'b0);
        s.ack = 1'b1;
        #1;
        checks++; if (m1.ack !== 1'b0 || m0.ack !== 1'b0) $display("FAIL rstmid_late_ack got m1=%b m0=%b exp 0/0", m1.ack, m0.ack); else passed++;
        tick();
        checks++; if (m1.ack !== 1'b0 || s.cyc !== 1'b0) $display("FAIL rstmid_idle got ack=%b cyc=%b exp 0/0", m1.ack, s.cyc); else passed++;
        s.ack = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b1;
        s.err  = 1'b0;
        test_reset();
        test_single_write();
        test_tie();
        test_burst();
        test_timeout();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
